proc_cpu_debug_monitor_ram: RTL and testbench
=============================================

Name: proc_cpu_debug_monitor_ram

Overview:
- Debug monitor memory feeding the CPU debug-slave wrapper: consumes its jdo and take_action_ocimem_a/b / take_no_action_ocimem_a strobes; returns MonDReg, monitor_ready, monitor_error.
- Single-port word RAM shared between the JTAG debug path and a CPU-side Avalon-MM slave. JTAG has priority; the CPU side stalls with waitrequest.
- Runs entirely in the system clock domain, beside the sysclk half of the debug slave.

Parameters:
- ADDR_W, 8, word-address width; RAM depth 2**ADDR_W x 32 bits.
- RESET_ADDR, 0, value loaded into MonAReg on reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG data-out from debug slave. Fields: [34:3] data, [ADDR_W+1:2] word address, [35] error-clear, [36] read-request.
- take_action_ocimem_a  in  1  1-cycle strobe: load address (plus optional read / error clear).
- take_no_action_ocimem_a  in  1  1-cycle strobe: increment address, then read.
- take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] at MonAReg, then increment.
- MonDReg  out  32  last JTAG read data.
- monitor_ready  out  1  JTAG operation complete.
- monitor_error  out  1  sticky: JTAG strobe dropped while busy.
- avs_address  in  ADDR_W  CPU word address.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU byte lanes.
- avs_readdata  out  32  CPU read data; valid when avs_read=1 and waitrequest=0.
- avs_waitrequest  out  1  stall.

Behaviour:
- Reset values: MonAReg=RESET_ADDR, MonDReg=0, monitor_ready=1, monitor_error=0, avs_readdata=0, avs_waitrequest=1, state=IDLE. RAM contents are not cleared.
- States: IDLE, J_RD, J_RDW, J_WR, C_RD, C_RDW, C_DONE. RAM read latency is 1 cycle (registered output).
- Command accept: only in IDLE. Strobe at cycle N clears monitor_ready at N+1.
  - ocimem_a: MonAReg <= jdo[ADDR_W+1:2].
    - If jdo[36]=1: go to J_RD.
    - Else: stay IDLE, monitor_ready stays 1.
    - If jdo[35]=1: clear monitor_error.
  - no_action_a: MonAReg+1 (wraps 2**ADDR_W-1 -> 0), then J_RD.
  - ocimem_b: J_WR with data latched.
- J_RD (N+1) issues RAM read. J_RDW (N+2): MonDReg <= q, monitor_ready=1 at N+2, return to IDLE.
- J_WR (N+1): RAM[MonAReg] <= data (all 4 bytes), MonAReg+1 with wrap, monitor_ready=1 at N+2, return to IDLE.
- Simultaneous strobes (not expected): priority ocimem_b > ocimem_a > no_action_a. Set monitor_error.
- Any strobe arriving outside IDLE: ignored, monitor_error <= 1.
- CPU access: accepted in IDLE only when no JTAG strobe is present that cycle. avs_waitrequest=1 in every state except C_DONE.
  - Read accepted at A: C_RD at A+1, C_RDW at A+2, C_DONE at A+3 (readdata valid, waitrequest=0), IDLE at A+4.
  - Write accepted at A: byte-masked write at A+1 in C_RD slot, C_DONE at A+2.
  - avs_read and avs_write both high: treated as write.
- JTAG strobe during a CPU transaction: monitor_error set, strobe dropped. The debugger retries.
- Reset mid-operation: abort at the next edge and return to reset values. A pending CPU access is lost; the master re-issues after waitrequest drops.

Optional Feature:
- Macro: PROC_CPU_DEBUG_MON_CPU_WRITE_EN.
- Defined: CPU writes modify RAM per byteenable, as above.
- Undefined: RAM is read-only from the CPU. Writes complete with identical handshake timing but leave RAM unchanged. The avs_writedata/avs_byteenable ports remain present and unused.

Test Plan:
- Reset, then ocimem_b with jdo[34:3]=0xDEADBEEF at MonAReg=0 -> monitor_ready low 1 cycle, then high; MonAReg=1.
- ocimem_a with addr=0, jdo[36]=1 -> MonDReg=0xDEADBEEF and monitor_ready=1 exactly 2 cycles after strobe.
- ocimem_a addr=0xFF (no read), then no_action_a -> address wraps to 0x00; MonDReg=0xDEADBEEF.
- CPU read addr 0 with a JTAG strobe in the same cycle -> JTAG served first; CPU sees waitrequest low with readdata=0xDEADBEEF after the JTAG op, 3 cycles after acceptance.
- CPU write 0x11223344, byteenable=0b0101, to addr 5 pre-loaded 0xAAAAAAAA -> JTAG read returns 0xAA22AA44. With macro undefined, returns 0xAAAAAAAA.
- Strobe during J_RDW -> monitor_error=1; ocimem_a with jdo[35]=1 clears it. Reset asserted during C_RDW -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/proc_cpu_debug_monitor_ram.sv
// Debug monitor word RAM shared by the JTAG debug path (priority) and a CPU Avalon-MM slave.
// Optional macro PROC_CPU_DEBUG_MON_CPU_WRITE_EN: when defined, CPU writes modify the RAM per byteenable.
module proc_cpu_debug_monitor_ram #(
  parameter int          ADDR_W     = 8,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

`ifdef PROC_CPU_DEBUG_MON_CPU_WRITE_EN
  localparam bit CPU_WR_EN = 1'b1;
`else
  localparam bit CPU_WR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_J_RD, S_J_RDW, S_J_WR, S_C_RD, S_C_RDW, S_C_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_areg;
  logic [31:0]       r_mon_dreg;
  logic              r_ready;
  logic              r_error;
  logic [31:0]       r_avs_rdata;
  logic [31:0]       r_jdata;
  logic [ADDR_W-1:0] r_caddr;
  logic [31:0]       r_cdata;
  logic [3:0]        r_cbe;
  logic              r_cwr;

  logic              w_any_strobe;
  logic              w_multi;
  logic              w_cpu_req;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_unused;

  assign w_any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_multi      = (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_no_action_ocimem_a & take_action_ocimem_b);
  assign w_cpu_req    = avs_read | avs_write;
  assign w_unused     = &{1'b0, jdo[37], jdo[1:0]};

  assign MonDReg         = r_mon_dreg;
  assign monitor_ready   = r_ready;
  assign monitor_error   = r_error;
  assign avs_readdata    = r_avs_rdata;
  assign avs_waitrequest = (r_state != S_C_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (take_action_ocimem_b)         w_next = S_J_WR;
        else if (take_action_ocimem_a)    w_next = jdo[36] ? S_J_RD : S_IDLE;
        else if (take_no_action_ocimem_a) w_next = S_J_RD;
        else if (w_cpu_req)               w_next = S_C_RD;
      end
      S_J_RD:   w_next = S_J_RDW;
      S_J_RDW:  w_next = S_IDLE;
      S_J_WR:   w_next = S_IDLE;
      S_C_RD:   w_next = r_cwr ? S_C_DONE : S_C_RDW;
      S_C_RDW:  w_next = S_C_DONE;
      S_C_DONE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The single RAM port is owned by JTAG in J_WR and by the CPU in C_RD.
  always_comb begin
    w_mem_addr = r_areg;
    w_be       = 4'h0;
    w_wdata    = r_jdata;
    if (r_state == S_J_WR) begin
      w_be = 4'hF;
    end else if (r_state == S_C_RD) begin
      w_mem_addr = r_caddr;
      w_wdata    = r_cdata;
      w_be       = (r_cwr && CPU_WR_EN) ? r_cbe : 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_mem_addr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_areg      <= ADDR_W'(RESET_ADDR);
      r_mon_dreg  <= 32'h0;
      r_ready     <= 1'b1;
      r_error     <= 1'b0;
      r_avs_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (take_action_ocimem_b) begin
            r_jdata <= jdo[34:3];
            r_ready <= 1'b0;
          end else if (take_action_ocimem_a) begin
            r_areg <= jdo[ADDR_W+1:2];
            if (jdo[36]) r_ready <= 1'b0;
            if (jdo[35]) r_error <= 1'b0;
          end else if (take_no_action_ocimem_a) begin
            r_areg  <= r_areg + ADDR_W'(1);
            r_ready <= 1'b0;
          end else if (w_cpu_req) begin
            r_caddr <= avs_address;
            r_cwr   <= avs_write;
            r_cdata <= avs_writedata;
            r_cbe   <= avs_byteenable;
          end
        end
        S_J_RD: begin
          r_mon_dreg <= r_mem[r_areg];
          r_ready    <= 1'b1;
        end
        S_J_WR: begin
          r_areg  <= r_areg + ADDR_W'(1);
          r_ready <= 1'b1;
        end
        S_C_RD: begin
          if (!r_cwr) r_avs_rdata <= r_mem[r_caddr];
        end
        default: ;
      endcase
      // A dropped or colliding strobe wins over an error-clear in the same cycle.
      if (w_any_strobe && (r_state != S_IDLE || w_multi)) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_cpu_debug_monitor_ram.sv
// Scoreboard bench for proc_cpu_debug_monitor_ram: random JTAG/CPU traffic against an array model.
module tb_proc_cpu_debug_monitor_ram;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  always #5 clk = ~clk;

  proc_cpu_debug_monitor_ram #(.ADDR_W(ADDR_W), .RESET_ADDR(0)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_areg;
  bit          m_err;

  typedef struct { bit rd; logic [31:0] data; } jexp_t;
  typedef struct { bit rd; logic [31:0] data; int done_cyc; } cexp_t;
  jexp_t jq[$];
  cexp_t cq[$];
  bit mon_en = 1'b0;

  initial begin
    jexp_t je;
    cexp_t ce;
    bit    prev_rdy;
    int    low_cnt;
    prev_rdy = 1'b1;
    low_cnt  = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (!monitor_ready) low_cnt++;
        else if (!prev_rdy) begin
          if (jq.size() == 0) chk("jtag_unexpected_done", 32'd1, 32'd0);
          else begin
            je = jq.pop_front();
            chk("jtag_ready_low_cycles", 32'(low_cnt), 32'd1);
            if (je.rd) chk("jtag_MonDReg", MonDReg, je.data);
          end
          low_cnt = 0;
        end
        prev_rdy = monitor_ready;
        if (!avs_waitrequest) begin
          if (cq.size() == 0) chk("cpu_unexpected_done", 32'd1, 32'd0);
          else begin
            ce = cq.pop_front();
            chk("cpu_done_cycle", 32'(cyc), 32'(ce.done_cyc));
            if (ce.rd) chk("cpu_readdata", avs_readdata, ce.data);
          end
        end
      end
    end
  end

  task automatic wait_jtag_done();
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (monitor_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("jtag_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_cpu_done();
    bit ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin ok = 1'b1; break; end
    end
    if (!ok) chk("cpu_waitrequest_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  // kind: 0 = ocimem_a, 1 = no_action_a, 2 = ocimem_b (dual also raises ocimem_a)
  task automatic jtag_op(input int kind, input logic [7:0] addr, input bit rd, input bit clr,
                         input logic [31:0] data, input bit dual);
    bit          busy = 1'b0;
    logic [37:0] j = '0;
    j[37]   = 1'($urandom);
    j[1:0]  = 2'($urandom);
    if (kind == 2) j[34:3] = data;
    else begin j[9:2] = addr; j[35] = clr; j[36] = rd; end
    @(posedge clk); #1;
    jdo = j;
    case (kind)
      0: begin
        take_action_ocimem_a = 1'b1;
        m_areg = addr;
        if (clr) m_err = 1'b0;
        if (rd) begin busy = 1'b1; jq.push_back('{1'b1, m_mem[m_areg]}); end
      end
      1: begin
        take_no_action_ocimem_a = 1'b1;
        m_areg = m_areg + 8'd1;
        busy = 1'b1;
        jq.push_back('{1'b1, m_mem[m_areg]});
      end
      default: begin
        take_action_ocimem_b = 1'b1;
        if (dual) begin take_action_ocimem_a = 1'b1; m_err = 1'b1; end
        m_mem[m_areg] = data;
        m_areg = m_areg + 8'd1;
        busy = 1'b1;
        jq.push_back('{1'b0, 32'h0});
      end
    endcase
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    if (busy) wait_jtag_done();
  endtask

  function automatic void model_cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
`ifdef PROC_CPU_DEBUG_MON_CPU_WRITE_EN
    logic [31:0] mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    m_mem[a] = (m_mem[a] & ~mask) | (d & mask);
`else
    if (a == 8'h0 && d == 32'h0 && be == 4'h0) m_mem[a] = m_mem[a];
`endif
  endfunction

  task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    avs_write = wr; avs_read = ~wr | ($urandom_range(0, 3) == 0);
    if (wr) begin model_cpu_write(a, d, be); cq.push_back('{1'b0, 32'h0, cyc + 2}); end
    else cq.push_back('{1'b1, m_mem[a], cyc + 3});
    wait_cpu_done();
  endtask

  initial begin
    int c;
    logic [7:0] ra;
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    logic [7:0] ra;
    reset = 1'b1; jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0; avs_byteenable = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_ready", {31'h0, monitor_ready}, 32'd1);
    chk("rst_error", {31'h0, monitor_error}, 32'd0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_waitrequest", {31'h0, avs_waitrequest}, 32'd1);
    reset = 1'b0; mon_en = 1'b1; m_areg = 8'h0; m_err = 1'b0;

    jtag_op(2, 8'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    jtag_op(0, 8'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("read_addr0", MonDReg, 32'hDEADBEEF);

    jtag_op(0, 8'h1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("noread_keeps_ready", {31'h0, monitor_ready}, 32'd1);
    for (int i = 1; i < DEPTH; i++) jtag_op(2, 8'h0, 1'b0, 1'b0, $urandom, 1'b0);

    jtag_op(0, 8'hFF, 1'b0, 1'b0, 32'h0, 1'b0);
    jtag_op(1, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_read_addr0", MonDReg, 32'hDEADBEEF);

    // JTAG read and CPU read of address 0 requested in the same cycle
    @(posedge clk); #1;
    c = cyc;
    jdo = '0; jdo[9:2] = 8'h0; jdo[36] = 1'b1;
    take_action_ocimem_a = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = 8'h0;
    m_areg = 8'h0;
    jq.push_back('{1'b1, m_mem[0]});
    cq.push_back('{1'b1, m_mem[0], c + 6});
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    wait_cpu_done();

    jtag_op(0, 8'h5, 1'b0, 1'b0, 32'h0, 1'b0);
    jtag_op(2, 8'h0, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b0);
    cpu_op(1'b1, 8'h5, 32'h11223344, 4'b0101);
    jtag_op(0, 8'h5, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef PROC_CPU_DEBUG_MON_CPU_WRITE_EN
    chk("cpu_bytewrite", MonDReg, 32'hAA22AA44);
`else
    chk("cpu_write_ignored", MonDReg, 32'hAAAAAAAA);
`endif

    // Strobe during J_RDW is dropped and flags an error
    @(posedge clk); #1;
    jdo = '0; jdo[9:2] = 8'h3; jdo[36] = 1'b1; take_action_ocimem_a = 1'b1;
    m_areg = 8'h3; jq.push_back('{1'b1, m_mem[3]});
    @(posedge clk); #1; take_action_ocimem_a = 1'b0;
    @(posedge clk); #1; take_no_action_ocimem_a = 1'b1; m_err = 1'b1;
    @(posedge clk); #1; take_no_action_ocimem_a = 1'b0;
    chk("err_strobe_in_jrdw", {31'h0, monitor_error}, 32'd1);
    jtag_op(0, 8'h3, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("err_cleared", {31'h0, monitor_error}, 32'd0);

    // Strobe during a CPU read is dropped; the CPU read still completes
    @(posedge clk); #1;
    c = cyc;
    avs_address = 8'h7; avs_read = 1'b1; avs_write = 1'b0;
    cq.push_back('{1'b1, m_mem[7], c + 3});
    @(posedge clk); #1;
    jdo = '0; jdo[34:3] = 32'h5A5A5A5A; take_action_ocimem_b = 1'b1; m_err = 1'b1;
    @(posedge clk); #1; take_action_ocimem_b = 1'b0;
    wait_cpu_done();
    chk("err_strobe_in_cpu", {31'h0, monitor_error}, 32'd1);
    jtag_op(0, 8'h7, 1'b1, 1'b1, 32'h0, 1'b0);
    chk("err_cleared_2", {31'h0, monitor_error}, 32'd0);

    // Simultaneous strobes: ocimem_b wins, error set
    jtag_op(2, 8'h0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1);
    chk("err_simultaneous", {31'h0, monitor_error}, 32'd1);
    jtag_op(0, m_areg - 8'd1, 1'b1, 1'b1, 32'h0, 1'b0);
    chk("simultaneous_b_wrote", MonDReg, 32'hCAFEF00D);

    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 5))
        0: jtag_op(2, 8'h0, 1'b0, 1'b0, $urandom, 1'b0);
        1: jtag_op(0, ra, 1'b1, 1'b0, 32'h0, 1'b0);
        2: jtag_op(1, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        3: cpu_op(1'b0, ra, 32'h0, 4'h0);
        4: cpu_op(1'b1, ra, $urandom, 4'($urandom));
        default: jtag_op(0, ra, 1'b0, 1'b0, 32'h0, 1'b0);
      endcase
    end
    chk("err_after_random", {31'h0, monitor_error}, {31'h0, m_err});

    // Reset during C_RDW with non-reset output state beforehand
    jtag_op(0, 8'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cpu_op(1'b0, 8'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    avs_address = 8'h0; avs_read = 1'b1; avs_write = 1'b0;
    @(posedge clk); #1;
    jdo = '0; take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    chk("err_before_reset", {31'h0, monitor_error}, 32'd1);
    reset = 1'b1; avs_read = 1'b0;
    @(posedge clk); #1;
    chk("midrst_MonDReg", MonDReg, 32'h0);
    chk("midrst_ready", {31'h0, monitor_ready}, 32'd1);
    chk("midrst_error", {31'h0, monitor_error}, 32'd0);
    chk("midrst_readdata", avs_readdata, 32'h0);
    chk("midrst_waitrequest", {31'h0, avs_waitrequest}, 32'd1);
    reset = 1'b0;
    cq.delete();
    m_areg = 8'h0; m_err = 1'b0;
    jtag_op(1, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cpu_op(1'b0, 8'h5, 32'h0, 4'h0);

    repeat (4) @(posedge clk);
    #1;
    chk("jtag_queue_drained", 32'(jq.size()), 32'd0);
    chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
